// File: rtl/seq_shifter_pkg.sv
// Shared constants for the sequential shifter: op encodings and control-state codes.
package seq_shifter_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_SLL = 2'b00;
  localparam op_t OP_SRL = 2'b01;
  localparam op_t OP_SRA = 2'b10;
  localparam op_t OP_RSV = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle between a shifter client (master) and seq_shifter (slave).
interface seq_shifter_if #(
  parameter int WIDTH = 32
);
  import seq_shifter_pkg::*;

  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // start while busy=1 is dropped. done pulses one cycle with result valid,
  // and busy is already 0 in that cycle so a new start is taken back-to-back.
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [0:0]       dbg_state;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result, dbg_state
  );

endinterface

// File: rtl/seq_shifter.sv
// Iterative one-bit-per-cycle shifter: SLL/SRL/SRA over shamt[SHW-1:0] edges,
// then a one-cycle done pulse with the result held until the next completion.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  seq_shifter_if.slave  bus
);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  op_t              r_op;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_acc_next;
  logic             w_unused_shamt;

  // Upper shamt bits come from the extender and carry no meaning here.
  assign w_unused_shamt = ^bus.shamt[WIDTH-1:SHW];

  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_SLL:  w_acc_next = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_acc_next = {1'b0, r_acc[WIDTH-1:1]};
      OP_SRA:  w_acc_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= OP_SLL;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_acc   <= bus.data_in;
            r_cnt   <= bus.shamt[SHW-1:0];
            r_op    <= bus.op;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - SHW'(1);
          end else begin
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_shifter_if #(.WIDTH(32)) bus ();

  seq_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain shift arithmetic on the low five shamt bits
  function automatic logic [31:0] model(op_t op, logic [31:0] d, logic [31:0] s);
    int n;
    n = int'(s[4:0]);
    case (op)
      OP_SLL:  return d << n;
      OP_SRL:  return d >> n;
      OP_SRA:  return 32'($signed(d) >>> n);
      default: return d;
    endcase
  endfunction

  // Driver: issue one request, scramble inputs after acceptance, and measure
  // edges to done plus any result change seen before done.
  task automatic drive_op(input op_t op, input logic [31:0] d, input logic [31:0] s,
                          output logic [31:0] res, output int lat, output int hold_bad);
    logic [31:0] prev;
    @(negedge clk);
    bus.op = op; bus.data_in = d; bus.shamt = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.op      = op_t'($urandom_range(0, 3));
    bus.data_in = $urandom;
    bus.shamt   = $urandom;
    prev     = bus.result;
    hold_bad = 0;
    lat      = 0;
    res      = 'x;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
      if (bus.result !== prev) hold_bad++;
    end
    if (!bus.done) lat = -1;
    res = bus.result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_vec++; if (bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %b want %b", bus.dbg_state, ST_IDLE); end
    bus.start = 1'b1; bus.op = OP_SLL; bus.data_in = 32'h1; bus.shamt = 32'h3;
    @(posedge clk); #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_over_start: busy got %b want 0", bus.busy); end
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat, hb;
    drive_op(OP_SLL, 32'h0000_0001, 32'h0000_0004, res, lat, hb);
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL sll4_latency: got %0d want 5", lat); end
    n_vec++; if (res !== 32'h0000_0010) begin n_err++; $display("FAIL sll4_result: got %h want 00000010", res); end
    @(posedge clk); #1;
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_single_cycle: got %b want 0", bus.done); end
    drive_op(OP_SRA, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, hb);
    n_vec++; if (lat != 32) begin n_err++; $display("FAIL sra31_latency: got %0d want 32", lat); end
    n_vec++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sra31_result: got %h want ffffffff", res); end
    n_vec++; if (hb != 0) begin n_err++; $display("FAIL sra31_result_hold: %0d early changes, want 0", hb); end
    drive_op(OP_SRL, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, hb);
    n_vec++; if (res !== 32'h0000_0001) begin n_err++; $display("FAIL srl31_result: got %h want 00000001", res); end
    drive_op(OP_SRL, 32'h1234_5678, 32'h0, res, lat, hb);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_vec++; if (res !== 32'h1234_5678) begin n_err++; $display("FAIL zero_result: got %h want 12345678", res); end
    drive_op(OP_RSV, 32'hA5A5_0F0F, 32'h7, res, lat, hb);
    n_vec++; if (res !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL rsv_result: got %h want a5a50f0f", res); end
  endtask

  task automatic test_random();
    logic [31:0] res, d, s;
    op_t op;
    int lat, hb;
    for (int i = 0; i < 24; i++) begin
      op = op_t'($urandom_range(0, 3));
      d  = $urandom;
      s  = $urandom;
      drive_op(op, d, s, res, lat, hb);
      n_vec++;
      if (res !== model(op, d, s) || lat != int'(s[4:0]) + 1 || hb != 0) begin
        n_err++;
        $display("FAIL random_%0d: op=%0d d=%h s=%h got res=%h lat=%0d hold=%0d want res=%h lat=%0d hold=0",
                 i, op, d, s, res, lat, hb, model(op, d, s), int'(s[4:0]) + 1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus.op = OP_SLL; bus.data_in = 32'h5; bus.shamt = 32'h3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.op = OP_SRL; bus.data_in = 32'hFFFF; bus.shamt = 32'h0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_during_op: got %b want 1", bus.busy); end
    lat = 1;
    while (lat < 40 && !bus.done) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 4", lat); end
    n_vec++; if (bus.result !== model(OP_SLL, 32'h5, 32'h3)) begin
      n_err++; $display("FAIL busy_ignore_result: got %h want %h", bus.result, model(OP_SLL, 32'h5, 32'h3));
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_ignore_no_restart: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.op = OP_SLL; bus.data_in = 32'h3; bus.shamt = 32'h2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.op = OP_SRA; bus.data_in = 32'hF000_0000; bus.shamt = 32'h4;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 3", lat); end
    n_vec++; if (bus.result !== model(OP_SLL, 32'h3, 32'h2)) begin
      n_err++; $display("FAIL b2b_first_result: got %h want %h", bus.result, model(OP_SLL, 32'h3, 32'h2));
    end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy: got %b want 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept: busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 5", lat); end
    n_vec++; if (bus.result !== model(OP_SRA, 32'hF000_0000, 32'h4)) begin
      n_err++; $display("FAIL b2b_second_result: got %h want %h", bus.result, model(OP_SRA, 32'hF000_0000, 32'h4));
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat, hb, n_done;
    @(negedge clk);
    bus.op = OP_SRL; bus.data_in = $urandom | 32'h8000_0000; bus.shamt = 32'd20; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL midreset_result: got %h want 0", bus.result); end
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL midreset_no_done: got %0d pulses want 0", n_done); end
    drive_op(OP_SLL, 32'h1, 32'h1, res, lat, hb);
    n_vec++; if (res !== 32'h2 || lat != 2) begin
      n_err++; $display("FAIL post_reset_op: got res=%h lat=%0d want res=00000002 lat=2", res, lat);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = OP_SLL;
    bus.data_in = '0;
    bus.shamt = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width; only 32 is supported.
REQ-002 The block SHALL have parameter SHW, default 5, number of shift-amount bits used.
REQ-003 The block SHALL use one clock, with a synchronous, active-high reset.
REQ-004 Port clk  input  1: the single clock; every register updates on its rising edge.
REQ-005 Port rst  input  1: synchronous reset, active-high.
REQ-006 Port start  input  1: request to begin a shift; sampled only while busy=0.
REQ-007 Port op  input  2: 00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
REQ-008 Port data_in  input  WIDTH: operand to shift.
REQ-009 Port shamt  input  WIDTH: extended shift amount from the shift-amount extender; only shamt[SHW-1:0] is used, upper bits are ignored.
REQ-010 Port busy  output  1: operation in progress.
REQ-011 Port done  output  1: single-cycle pulse; result is valid in that cycle.
REQ-012 Port result  output  WIDTH: last completed result; held until the next done.

Function
REQ-013 Acceptance: on an edge with start=1 and busy=0, the block SHALL load acc=data_in, cnt=shamt[4:0] and op_r=op, and set busy=1.
REQ-014 start while busy=1 SHALL be ignored, with no effect on acc, cnt, op_r or the outputs.
REQ-015 On each edge with busy=1 and cnt!=0, the block SHALL shift acc one bit and decrement cnt by 1:
- SLL: insert 0 at the LSB.
- SRL: insert 0 at the MSB.
- SRA: replicate acc[31] at the MSB.
- op 11: leave acc unchanged.
REQ-016 On the edge with busy=1 and cnt==0, the block SHALL set result=acc, done=1 and busy=0.
REQ-017 Latency SHALL be shamt[4:0]+1 edges from the accepting edge to the edge that raises done (shamt=0 gives 1 edge; shamt=31 gives 32 edges).
REQ-018 done SHALL be high for exactly one cycle and otherwise low.
REQ-019 Back-to-back: start=1 in the cycle where done=1 SHALL be accepted, because busy=0 in that cycle.
REQ-020 Inputs data_in, shamt and op SHALL be sampled only at acceptance; later changes SHALL NOT affect the running operation.
REQ-021 result SHALL change only on the edge that raises done.

Reset
REQ-022 When rst=1 at an edge, the block SHALL set busy=0, done=0, result=0, acc=0, cnt=0 and op_r=00; reset overrides start.
REQ-023 Reset mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-024 Op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSV) SHALL be defined in the shared CPU constants package, not locally.
REQ-025 The block SHALL be a single module with no sub-modules: a 2-state control (IDLE, SHIFT) plus the datapath registers acc, cnt and op_r.
REQ-026 The state transitions SHALL be:
- IDLE -> SHIFT on start.
- SHIFT -> SHIFT while cnt!=0.
- SHIFT -> IDLE when cnt==0, raising done.

Verification
REQ-027 SLL: data_in=0x0000_0001, shamt=0x0000_0004, start -> done 5 edges later, result=0x0000_0010.
REQ-028 SRA sign fill: data_in=0x8000_0000, shamt=0xFFFF_FFFF (extended -1, low bits 31) -> done after 32 edges, result=0xFFFF_FFFF; the same operand with SRL gives 0x0000_0001.
REQ-029 Zero shift: op=SRL, data_in=0x1234_5678, shamt=0 -> done 1 edge later, result=0x1234_5678.
REQ-030 Busy and back-to-back:
- During SLL shamt=3, pulse start with other data -> ignored, result unchanged by it.
- start held in the done cycle -> second op accepted, busy high again next cycle.
REQ-031 Reset mid-op: SRL shamt=20, rst at edge 5 -> busy=0, result=0, no done pulse; a new SLL 0x1 by 1 then yields 0x2.
